eth_tx_pkt_buf: RTL

- Store-and-forward packet buffer between the application writer and eth_tx.
- Accepts packet words at the writer's own pace and commits a packet only on its last word.
- Then presents the packet to eth_tx using the early_v / ready_v / valid handshake, with total packet length and UDP checksum available up front.
- Parametrised in data width, buffer depth and number of queued packets; supports writer-side cancel and oversize-packet drop.

---
 rtl/eth_tx_pkt_buf_if.sv | 35 +++
 rtl/eth_tx_pkt_buf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pkt_buf_if.sv
// Writer and eth_tx facing signals of the store-and-forward TX packet buffer.
// slave is the buffer's view; master is the writer/consumer view.
interface eth_tx_pkt_buf_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LEN_W     = 2,
    parameter int unsigned PKT_LEN_W = 16,
    parameter int unsigned UDP_CS_W  = 16
);
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [DATA_W-1:0]    wr_data_i;
    logic [LEN_W-1:0]     wr_len_i;
    logic                 wr_last_i;
    logic                 wr_cancel_i;
    logic [UDP_CS_W-1:0]  wr_cs_i;
    logic                 app_early_v_o;
    logic                 app_ready_v_i;
    logic                 app_valid_o;
    logic [DATA_W-1:0]    app_data_o;
    logic [LEN_W-1:0]     app_len_o;
    logic [PKT_LEN_W-1:0] app_pkt_len_o;
    logic [UDP_CS_W-1:0]  app_cs_o;

    modport slave (
        input  wr_valid_i, wr_data_i, wr_len_i, wr_last_i, wr_cancel_i, wr_cs_i, app_ready_v_i,
        output wr_ready_o, app_early_v_o, app_valid_o, app_data_o, app_len_o, app_pkt_len_o,
               app_cs_o
    );

    modport master (
        output wr_valid_i, wr_data_i, wr_len_i, wr_last_i, wr_cancel_i, wr_cs_i, app_ready_v_i,
        input  wr_ready_o, app_early_v_o, app_valid_o, app_data_o, app_len_o, app_pkt_len_o,
               app_cs_o
    );
endinterface

// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward TX packet buffer: packets are committed on their last word and then
// presented to eth_tx with length and checksum known before the first data word.
module eth_tx_pkt_buf #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned KEEP_W    = DATA_W / 8,
    parameter int unsigned LEN_W     = $clog2(KEEP_W + 1),
    parameter int unsigned PKT_LEN_W = 16,
    parameter int unsigned UDP_CS_W  = 16,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned PKT_N     = 4
) (
    input  logic                         clk,
    input  logic                         nreset,
    eth_tx_pkt_buf_if.slave              bus,
    output logic [$clog2(PKT_N+1)-1:0]   pkt_cnt_o,
    output logic                         drop_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned MW    = $clog2(PKT_N);
    localparam int unsigned KB    = $clog2(KEEP_W);
    localparam int unsigned CNT_W = $clog2(PKT_N + 1);

    localparam logic [AW:0]        PtrOne  = 1;
    localparam logic [MW:0]        MPtrOne = 1;
    localparam logic [CNT_W-1:0]   CntOne  = 1;
    localparam logic [LEN_W-1:0]   FullLen = LEN_W'(KEEP_W);
    localparam logic [PKT_LEN_W-1:0] LenOne = 1;
    localparam logic [PKT_LEN_W-1:0] LenTwo = 2;

    typedef enum logic [1:0] {StIdle, StHead, StStream} state_e;

    // Storage
    logic [DATA_W-1:0]    r_mem      [DEPTH];
    logic [PKT_LEN_W-1:0] r_meta_len [PKT_N];
    logic [UDP_CS_W-1:0]  r_meta_cs  [PKT_N];

    // Write side
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_cm_ptr;
    logic [PKT_LEN_W-1:0] r_acc;
    logic [MW:0]          r_mw_ptr;
    logic                 r_discard;
    logic                 r_drop;
    logic                 r_active;
    logic [CNT_W-1:0]     r_pkt_cnt;

    // Read side
    state_e               r_state;
    logic [AW:0]          r_rd_ptr;
    logic [MW:0]          r_mr_ptr;
    logic                 r_early;
    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [LEN_W-1:0]     r_len;
    logic [PKT_LEN_W-1:0] r_pkt_len;
    logic [PKT_LEN_W-1:0] r_left;
    logic [UDP_CS_W-1:0]  r_cs;

    logic                 w_data_full;
    logic                 w_meta_full;
    logic                 w_meta_empty;
    logic [MW:0]          w_meta_cnt;
    logic                 w_oversize;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_cancel;
    logic                 w_word;
    logic                 w_commit;
    logic                 w_pop;
    logic [PKT_LEN_W-1:0] w_acc_next;
    logic [AW:0]          w_wr_ptr_inc;
    logic [MW:0]          w_mr_ptr_inc;
    logic [PKT_LEN_W-1:0] w_words;
    logic [LEN_W-1:0]     w_last_len;

    assign w_data_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_meta_full  = (r_mw_ptr[MW] != r_mr_ptr[MW]) &&
                          (r_mw_ptr[MW-1:0] == r_mr_ptr[MW-1:0]);
    assign w_meta_empty = (r_mw_ptr == r_mr_ptr);
    assign w_meta_cnt   = r_mw_ptr - r_mr_ptr;

    // Buffer holds only the packet being written and can never drain: it cannot fit.
    assign w_oversize   = w_data_full && w_meta_empty && (r_state == StIdle) && !r_discard;
    assign w_ready      = r_active && (r_discard || w_oversize || (!w_data_full && !w_meta_full));
    assign w_accept     = bus.wr_valid_i && w_ready;
    assign w_cancel     = bus.wr_valid_i && bus.wr_cancel_i;
    assign w_word       = w_accept && !bus.wr_cancel_i && !r_discard && !w_oversize;
    assign w_acc_next   = r_acc + PKT_LEN_W'(bus.wr_len_i);
    assign w_wr_ptr_inc = r_wr_ptr + PtrOne;
    assign w_commit     = w_word && bus.wr_last_i && (w_acc_next != '0);

    assign w_mr_ptr_inc = r_mr_ptr + MPtrOne;
    assign w_pop        = (r_state == StStream) && (r_left == LenOne);
    assign w_words      = PKT_LEN_W'(r_pkt_len >> KB) + PKT_LEN_W'(|r_pkt_len[KB-1:0]);
    assign w_last_len   = (r_pkt_len[KB-1:0] == '0) ? FullLen : LEN_W'(r_pkt_len[KB-1:0]);

    always_ff @(posedge clk) begin
        if (w_word) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_meta_len[r_mw_ptr[MW-1:0]] <= w_acc_next;
            r_meta_cs[r_mw_ptr[MW-1:0]]  <= bus.wr_cs_i;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr  <= '0;
            r_cm_ptr  <= '0;
            r_acc     <= '0;
            r_mw_ptr  <= '0;
            r_discard <= 1'b0;
            r_drop    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_drop   <= 1'b0;
            if (r_discard) begin
                if (w_cancel || (w_accept && bus.wr_last_i)) begin
                    r_discard <= 1'b0;
                end
            end else if (w_cancel) begin
                r_wr_ptr <= r_cm_ptr;
                r_acc    <= '0;
            end else if (w_accept && w_oversize) begin
                r_wr_ptr  <= r_cm_ptr;
                r_acc     <= '0;
                r_drop    <= 1'b1;
                r_discard <= !bus.wr_last_i;
            end else if (w_word) begin
                if (!bus.wr_last_i) begin
                    r_wr_ptr <= w_wr_ptr_inc;
                    r_acc    <= w_acc_next;
                end else if (w_commit) begin
                    r_wr_ptr <= w_wr_ptr_inc;
                    r_cm_ptr <= w_wr_ptr_inc;
                    r_acc    <= '0;
                    r_mw_ptr <= r_mw_ptr + MPtrOne;
                end else begin
                    // Zero-length packet: nothing to keep.
                    r_wr_ptr <= r_cm_ptr;
                    r_acc    <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pkt_cnt <= '0;
        end else begin
            case ({w_commit, w_pop})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + CntOne;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - CntOne;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= StIdle;
            r_rd_ptr  <= '0;
            r_mr_ptr  <= '0;
            r_early   <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_len     <= '0;
            r_pkt_len <= '0;
            r_left    <= '0;
            r_cs      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_meta_empty) begin
                        r_state   <= StHead;
                        r_early   <= 1'b1;
                        r_pkt_len <= r_meta_len[r_mr_ptr[MW-1:0]];
                        r_cs      <= r_meta_cs[r_mr_ptr[MW-1:0]];
                        r_data    <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rd_ptr  <= r_rd_ptr + PtrOne;
                    end
                end
                StHead: begin
                    // First word is already in r_data from the prefetch.
                    if (bus.app_ready_v_i) begin
                        r_state <= StStream;
                        r_early <= 1'b0;
                        r_valid <= 1'b1;
                        r_left  <= w_words;
                        r_len   <= (w_words == LenOne) ? w_last_len : FullLen;
                    end
                end
                StStream: begin
                    if (r_left == LenOne) begin
                        r_mr_ptr <= w_mr_ptr_inc;
                        r_valid  <= 1'b0;
                        r_left   <= '0;
                        if (w_meta_cnt > MPtrOne) begin
                            r_state   <= StHead;
                            r_early   <= 1'b1;
                            r_len     <= '0;
                            r_pkt_len <= r_meta_len[w_mr_ptr_inc[MW-1:0]];
                            r_cs      <= r_meta_cs[w_mr_ptr_inc[MW-1:0]];
                            r_data    <= r_mem[r_rd_ptr[AW-1:0]];
                            r_rd_ptr  <= r_rd_ptr + PtrOne;
                        end else begin
                            r_state   <= StIdle;
                            r_data    <= '0;
                            r_len     <= '0;
                            r_pkt_len <= '0;
                            r_cs      <= '0;
                        end
                    end else begin
                        r_data   <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rd_ptr <= r_rd_ptr + PtrOne;
                        r_left   <= r_left - LenOne;
                        r_len    <= (r_left == LenTwo) ? w_last_len : FullLen;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.wr_ready_o    = w_ready;
    assign bus.app_early_v_o = r_early;
    assign bus.app_valid_o   = r_valid;
    assign bus.app_data_o    = r_data;
    assign bus.app_len_o     = r_len;
    assign bus.app_pkt_len_o = r_pkt_len;
    assign bus.app_cs_o      = r_cs;
    assign pkt_cnt_o         = r_pkt_cnt;
    assign drop_o            = r_drop;
endmodule
